// File: rtl/phototape_start_if.sv
// Tape reader handshake and forwarded-character bus of the phototape start block.
// master: tape reader / downstream consumer side; slave: phototape_start.
interface phototape_start_if;
  logic       TAPE_VALID;
  logic [4:0] TAPE_CHAR;
  logic       TAPE_READY;
  logic       DATA_VALID;
  logic [4:0] DATA_CHAR;
  logic       DATA_TO_NT;

  modport master (
    output TAPE_VALID, TAPE_CHAR,
    input  TAPE_READY, DATA_VALID, DATA_CHAR, DATA_TO_NT
  );

  modport slave (
    input  TAPE_VALID, TAPE_CHAR,
    output TAPE_READY, DATA_VALID, DATA_CHAR, DATA_TO_NT
  );
endinterface

// File: rtl/phototape_start.sv
// Auto tape start: spins up the reader, forwards one tape block up to the stop code, then brakes.
// Optional read timeout to a latched FAULT state is enabled by defining G15_TAPE_TIMEOUT_EN.
module phototape_start #(
  parameter int         SPINUP_MS  = 50,
  parameter int         BRAKE_MS   = 25,
  parameter int         TIMEOUT_MS = 2000,
  parameter logic [4:0] STOP_CODE  = 5'b00010
) (
  input  logic                CLOCK,
  input  logic                rst,
  input  logic                tick_ms,
  input  logic                PWR_AUTO_TAPE_START,
  input  logic                PWR_NT,
  phototape_start_if.slave    bus,
  output logic                MOTOR_ON,
  output logic                WAIT_FOR_TAPE,
  output logic                LITE_TAPE_FAULT
);

  localparam logic [15:0] SPINUP_LIM  = 16'(SPINUP_MS);
  localparam logic [15:0] BRAKE_LIM   = 16'(BRAKE_MS);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE, S_SPINUP, S_READ, S_BRAKE, S_FAULT
  } state_e;

  typedef struct packed {
    logic motor;
    logic wait_tape;
    logic ready;
    logic fault;
  } ctl_t;

  // Output pattern of each state, loaded together with the state so outputs come straight from flops.
  function automatic ctl_t ctl_of(state_e s);
    ctl_t c;
    c           = '0;
    c.motor     = (s == S_SPINUP) || (s == S_READ);
    c.wait_tape = (s != S_IDLE);
    c.ready     = (s == S_READ);
    c.fault     = (s == S_FAULT);
    return c;
  endfunction

  state_e      state;
  ctl_t        ctl;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic        pwr_prev;
  logic        nt_flag;
  logic        data_valid;
  logic [4:0]  data_char;
  logic        start_edge;
  logic        transfer;

  assign cnt_inc    = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign start_edge = PWR_AUTO_TAPE_START && !pwr_prev;
  assign transfer   = bus.TAPE_VALID && ctl.ready;

  always_ff @(posedge CLOCK) begin
    // NOTE: the edge register also loads during rst, so a level held high through reset is never an edge.
    pwr_prev <= PWR_AUTO_TAPE_START;
    if (rst) begin
      state      <= S_IDLE;
      ctl        <= '0;
      cnt        <= '0;
      nt_flag    <= 1'b0;
      data_valid <= 1'b0;
      data_char  <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state   <= S_SPINUP;
            ctl     <= ctl_of(S_SPINUP);
            cnt     <= '0;
            nt_flag <= PWR_NT;
          end
        end
        S_SPINUP: begin
          if (tick_ms) begin
            if (cnt_inc >= SPINUP_LIM) begin
              state <= S_READ;
              ctl   <= ctl_of(S_READ);
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_READ: begin
          // A transfer restarts the inter-character timer even when a tick lands in the same cycle.
          if (transfer) begin
            cnt <= '0;
            if (bus.TAPE_CHAR == STOP_CODE) begin
              state <= S_BRAKE;
              ctl   <= ctl_of(S_BRAKE);
            end else begin
              data_valid <= 1'b1;
              data_char  <= bus.TAPE_CHAR;
            end
          end else if (tick_ms) begin
`ifdef G15_TAPE_TIMEOUT_EN
            if (cnt_inc >= TIMEOUT_LIM) begin
              state <= S_FAULT;
              ctl   <= ctl_of(S_FAULT);
            end
`endif
            cnt <= cnt_inc;
          end
        end
        S_BRAKE: begin
          if (tick_ms) begin
            if (cnt_inc >= BRAKE_LIM) begin
              state <= S_IDLE;
              ctl   <= ctl_of(S_IDLE);
              cnt   <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        S_FAULT: begin
          if (tick_ms) cnt <= cnt_inc;
        end
        default: begin
          state <= S_IDLE;
          ctl   <= '0;
        end
      endcase
    end
  end

  assign bus.TAPE_READY = ctl.ready;
  assign bus.DATA_VALID = data_valid;
  assign bus.DATA_CHAR  = data_char;
  assign bus.DATA_TO_NT = nt_flag;
  assign MOTOR_ON       = ctl.motor;
  assign WAIT_FOR_TAPE  = ctl.wait_tape;

`ifdef G15_TAPE_TIMEOUT_EN
  assign LITE_TAPE_FAULT = ctl.fault;
`else
  logic unused_cfg;
  assign LITE_TAPE_FAULT = 1'b0;
  assign unused_cfg      = ctl.fault ^ (^TIMEOUT_LIM);
`endif

endmodule

// File: tb/tb_phototape_start.sv
// Self-checking bench for phototape_start: vector table, directed corner sequences and a
// randomized run compared cycle by cycle against a tick-timestamp reference model.
module tb_phototape_start;

  localparam int         SPINUP     = 50;
  localparam int         BRAKE      = 25;
  localparam int         TIMEOUT    = 10;
  localparam logic [4:0] STOP       = 5'b00010;

  logic CLOCK = 1'b0;
  logic rst;
  logic tick_ms;
  logic PWR_AUTO_TAPE_START;
  logic PWR_NT;
  logic MOTOR_ON;
  logic WAIT_FOR_TAPE;
  logic LITE_TAPE_FAULT;

  phototape_start_if bus ();

  phototape_start #(
    .SPINUP_MS  (SPINUP),
    .BRAKE_MS   (BRAKE),
    .TIMEOUT_MS (TIMEOUT),
    .STOP_CODE  (STOP)
  ) dut (
    .CLOCK               (CLOCK),
    .rst                 (rst),
    .tick_ms             (tick_ms),
    .PWR_AUTO_TAPE_START (PWR_AUTO_TAPE_START),
    .PWR_NT              (PWR_NT),
    .bus                 (bus),
    .MOTOR_ON            (MOTOR_ON),
    .WAIT_FOR_TAPE       (WAIT_FOR_TAPE),
    .LITE_TAPE_FAULT     (LITE_TAPE_FAULT)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // {LITE, WAIT, MOTOR, READY, DATA_VALID, DATA_TO_NT, DATA_CHAR}
  function automatic logic [10:0] outs();
    return {LITE_TAPE_FAULT, WAIT_FOR_TAPE, MOTOR_ON, bus.TAPE_READY,
            bus.DATA_VALID, bus.DATA_TO_NT, bus.DATA_CHAR};
  endfunction

  // Reference model: phase plus a global tick count; a phase ends once enough ticks have
  // elapsed since its timestamp.
  typedef enum int {M_IDLE, M_SPIN, M_READ, M_BRAKE, M_FAULT} phase_e;
  phase_e     m_phase = M_IDLE;
  int         m_ticks = 0;
  int         m_stamp = 0;
  logic       m_prev  = 1'b0;
  logic       m_nt    = 1'b0;
  logic       m_dv    = 1'b0;
  logic [4:0] m_ch    = '0;

  task automatic model_edge();
    logic rising;
    if (rst) begin
      m_phase = M_IDLE;
      m_nt    = 1'b0;
      m_dv    = 1'b0;
      m_ch    = '0;
      m_prev  = PWR_AUTO_TAPE_START;
    end else begin
      rising = PWR_AUTO_TAPE_START && !m_prev;
      m_prev = PWR_AUTO_TAPE_START;
      m_dv   = 1'b0;
      if (tick_ms) m_ticks++;
      case (m_phase)
        M_IDLE:  if (rising) begin m_phase = M_SPIN; m_stamp = m_ticks; m_nt = PWR_NT; end
        M_SPIN:  if (m_ticks - m_stamp >= SPINUP) begin m_phase = M_READ; m_stamp = m_ticks; end
        M_READ: begin
          if (bus.TAPE_VALID) begin
            m_stamp = m_ticks;
            if (bus.TAPE_CHAR == STOP) m_phase = M_BRAKE;
            else begin m_dv = 1'b1; m_ch = bus.TAPE_CHAR; end
          end
`ifdef G15_TAPE_TIMEOUT_EN
          else if (m_ticks - m_stamp >= TIMEOUT) m_phase = M_FAULT;
`endif
        end
        M_BRAKE: if (m_ticks - m_stamp >= BRAKE) m_phase = M_IDLE;
        default: ;
      endcase
    end
  endtask

  function automatic logic [10:0] model_outs();
    return {m_phase == M_FAULT, m_phase != M_IDLE,
            (m_phase == M_SPIN) || (m_phase == M_READ), m_phase == M_READ,
            m_dv, m_nt, m_ch};
  endfunction

  // One clock: drive at negedge, model on posedge, compare 1 time unit after the edge.
  task automatic step(input logic r, input logic tk, input logic v, input logic [4:0] c);
    @(negedge CLOCK);
    rst             = r;
    tick_ms         = tk;
    bus.TAPE_VALID  = v;
    bus.TAPE_CHAR   = c;
    @(posedge CLOCK);
    cyc++;
    model_edge();
    #1;
    check("model", 32'(outs()), 32'(model_outs()));
  endtask

  // Bounded spin-up: returns number of tick cycles needed until TAPE_READY.
  task automatic spin_to_read(output int n);
    n = 0;
    while (!bus.TAPE_READY && n < 4 * SPINUP) begin
      step(1'b0, 1'b1, 1'b0, 5'h00);
      n++;
    end
  endtask

  task automatic brake_to_idle(output int n);
    n = 0;
    while (WAIT_FOR_TAPE && n < 4 * BRAKE) begin
      step(1'b0, 1'b1, 1'b0, 5'h00);
      n++;
    end
  endtask

  typedef struct {
    logic        v;
    logic [4:0]  c;
    logic        tk;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [7];
  int   n;

  initial begin
    vecs[0] = '{v: 1'b0, c: 5'h00, tk: 1'b0, exp: 11'b0111_00_00000};
    vecs[1] = '{v: 1'b1, c: 5'h03, tk: 1'b0, exp: 11'b0111_10_00011};
    vecs[2] = '{v: 1'b0, c: 5'h00, tk: 1'b1, exp: 11'b0111_00_00011};
    vecs[3] = '{v: 1'b1, c: 5'h11, tk: 1'b1, exp: 11'b0111_10_10001};
    vecs[4] = '{v: 1'b1, c: 5'h1F, tk: 1'b0, exp: 11'b0111_10_11111};
    vecs[5] = '{v: 1'b1, c: STOP,  tk: 1'b0, exp: 11'b0100_00_11111};
    vecs[6] = '{v: 1'b1, c: 5'h07, tk: 1'b1, exp: 11'b0100_00_11111};

    PWR_AUTO_TAPE_START = 1'b0;
    PWR_NT              = 1'b0;
    rst                 = 1'b1;
    tick_ms             = 1'b0;
    bus.TAPE_VALID      = 1'b0;
    bus.TAPE_CHAR       = '0;

    step(1'b1, 1'b0, 1'b0, 5'h00);
    step(1'b1, 1'b0, 1'b0, 5'h00);
    check("reset_outputs", 32'(outs()), 32'd0);

    // Start level held high through reset release must not start a block.
    PWR_AUTO_TAPE_START = 1'b1;
    step(1'b1, 1'b0, 1'b0, 5'h00);
    repeat (5) step(1'b0, 1'b1, 1'b0, 5'h00);
    check("no_start_through_rst", 32'(WAIT_FOR_TAPE), 32'd0);

    // Basic block: 03, 11, stop.
    PWR_AUTO_TAPE_START = 1'b0;
    step(1'b0, 1'b0, 1'b0, 5'h00);
    PWR_AUTO_TAPE_START = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'h00);
    check("spinup_entry", 32'({MOTOR_ON, WAIT_FOR_TAPE, bus.TAPE_READY}), 32'b110);
    spin_to_read(n);
    check("spinup_ticks", 32'(n), 32'(SPINUP));
    for (int i = 0; i < 7; i++) begin
      step(1'b0, vecs[i].tk, vecs[i].v, vecs[i].c);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    brake_to_idle(n);
    check("brake_ticks", 32'(n + 1), 32'(BRAKE));
    repeat (30) step(1'b0, 1'b1, 1'b0, 5'h00);
    check("no_restart_level_high", 32'(WAIT_FOR_TAPE), 32'd0);

    // NT latched at the start edge; a second start edge during READ is ignored.
    PWR_AUTO_TAPE_START = 1'b0;
    step(1'b0, 1'b0, 1'b0, 5'h00);
    PWR_NT              = 1'b1;
    PWR_AUTO_TAPE_START = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'h00);
    PWR_NT = 1'b0;
    spin_to_read(n);
    check("spinup_ticks_nt", 32'(n), 32'(SPINUP));
    step(1'b0, 1'b0, 1'b1, 5'h0A);
    check("nt_char0", 32'({bus.DATA_VALID, bus.DATA_TO_NT, bus.DATA_CHAR}), 32'b11_01010);
    PWR_AUTO_TAPE_START = 1'b0;
    step(1'b0, 1'b0, 1'b0, 5'h00);
    PWR_AUTO_TAPE_START = 1'b1;
    step(1'b0, 1'b1, 1'b0, 5'h00);
    check("second_edge_ignored", 32'({MOTOR_ON, bus.TAPE_READY}), 32'b11);
    step(1'b0, 1'b0, 1'b1, 5'h15);
    check("nt_char1", 32'({bus.DATA_VALID, bus.DATA_TO_NT, bus.DATA_CHAR}), 32'b11_10101);
    step(1'b0, 1'b0, 1'b1, STOP);
    check("stop_not_forwarded", 32'({bus.DATA_VALID, bus.TAPE_READY}), 32'b00);
    brake_to_idle(n);
    check("brake_ticks_nt", 32'(n), 32'(BRAKE));
    repeat (30) step(1'b0, 1'b1, 1'b0, 5'h00);
    check("single_block_only", 32'(WAIT_FOR_TAPE), 32'd0);

    // Reset in READ with a character pending.
    PWR_AUTO_TAPE_START = 1'b0;
    step(1'b0, 1'b0, 1'b0, 5'h00);
    PWR_AUTO_TAPE_START = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'h00);
    spin_to_read(n);
    step(1'b1, 1'b0, 1'b1, 5'h05);
    check("rst_in_read", 32'(outs()), 32'd0);
    step(1'b0, 1'b0, 1'b1, 5'h05);
    check("after_rst_idle", 32'(outs()), 32'd0);

    // Read timeout behaviour.
    PWR_AUTO_TAPE_START = 1'b0;
    step(1'b0, 1'b0, 1'b0, 5'h00);
    PWR_AUTO_TAPE_START = 1'b1;
    step(1'b0, 1'b0, 1'b0, 5'h00);
    spin_to_read(n);
`ifdef G15_TAPE_TIMEOUT_EN
    n = 0;
    while (!LITE_TAPE_FAULT && n < 10 * TIMEOUT) begin
      step(1'b0, 1'b1, 1'b0, 5'h00);
      n++;
    end
    check("timeout_ticks", 32'(n), 32'(TIMEOUT));
    check("fault_outputs", 32'({LITE_TAPE_FAULT, WAIT_FOR_TAPE, MOTOR_ON, bus.TAPE_READY}), 32'b1100);
    PWR_AUTO_TAPE_START = 1'b0;
    repeat (20) step(1'b0, 1'b1, 1'b1, 5'h03);
    PWR_AUTO_TAPE_START = 1'b1;
    repeat (5) step(1'b0, 1'b1, 1'b0, 5'h00);
    check("fault_sticky", 32'({LITE_TAPE_FAULT, WAIT_FOR_TAPE}), 32'b11);
`else
    repeat (5000) step(1'b0, 1'b1, 1'b0, 5'h00);
    check("no_timeout", 32'({LITE_TAPE_FAULT, WAIT_FOR_TAPE, MOTOR_ON, bus.TAPE_READY}), 32'b0111);
`endif
    step(1'b1, 1'b0, 1'b0, 5'h00);
    check("rst_clears", 32'(outs()), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic       r;
      logic       tk;
      logic       v;
      logic [4:0] c;
      if ($urandom_range(0, 39) == 0) begin
        PWR_AUTO_TAPE_START = ~PWR_AUTO_TAPE_START;
        PWR_NT              = 1'($urandom_range(0, 1));
      end
      r  = ($urandom_range(0, 299) == 0);
      tk = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 7) == 0) ? STOP : 5'($urandom_range(0, 31));
      step(r, tk, v, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
